// File: rtl/alu_operand_sequencer_if.sv
// rtl/alu_operand_sequencer_if.sv - switch, button and ALU operand/result bundle for the operand sequencer
interface alu_operand_sequencer_if #(
   parameter int WIDTH = 4,
   parameter int OPW   = 4,
   parameter int SW_W  = 4
);
   logic [SW_W-1:0]  sw;
   logic             btn_enter;
   logic             btn_clear;
   logic [WIDTH-1:0] alu_y;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [OPW-1:0]   op;
   logic [WIDTH-1:0] result;
   logic             result_valid;
   logic             busy;
   logic [2:0]       phase;

   modport master (
      input  sw, btn_enter, btn_clear, alu_y,
      output A, B, op, result, result_valid, busy, phase
   );

   modport slave (
      output sw, btn_enter, btn_clear, alu_y,
      input  A, B, op, result, result_valid, busy, phase
   );
endinterface

// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - button-driven A/B/op entry front end for a registered ALU
module alu_operand_sequencer #(
   parameter int WIDTH     = 4,
   parameter int OPW       = 4,
   parameter int SW_W      = 4,
   parameter int DB_CYCLES = 4,
   parameter int ALU_LAT   = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   alu_operand_sequencer_if.master bus
);
   localparam int DBW = $clog2(DB_CYCLES + 1);
   localparam int WCW = $clog2(ALU_LAT + 1);
   localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
   localparam logic [WCW-1:0] WAIT_INIT = WCW'(ALU_LAT);

   typedef enum logic [2:0] {
      LOAD_A  = 3'd0,
      LOAD_B  = 3'd1,
      LOAD_OP = 3'd2,
      WAIT    = 3'd3,
      SHOW    = 3'd4
   } state_t;

   state_t         state;
   // bit 0 is the enter button, bit 1 the clear button
   logic [1:0]     raw;
   logic [1:0]     sync1;
   logic [1:0]     sync2;
   logic [1:0]     level;
   logic [1:0]     press;
   logic [DBW-1:0] db_cnt [2];
   logic [WCW-1:0] wait_cnt;

   assign raw = {bus.btn_clear, bus.btn_enter};

   // synchronize, debounce and rising-edge detect both buttons; press is a registered one-cycle pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1     <= '0;
         sync2     <= '0;
         level     <= '0;
         press     <= '0;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < 2; i++) begin
            press[i] <= 1'b0;
            if (sync2[i] == level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_cnt[i] <= '0;
               level[i]  <= sync2[i];
               press[i]  <= sync2[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // operand entry, ALU latency wait and result capture; a clear press overrides everything
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= LOAD_A;
         bus.A            <= '0;
         bus.B            <= '0;
         bus.op           <= '0;
         bus.result       <= '0;
         bus.result_valid <= 1'b0;
         wait_cnt         <= '0;
      end else if (press[1]) begin
         state            <= LOAD_A;
         bus.A            <= '0;
         bus.B            <= '0;
         bus.op           <= '0;
         bus.result       <= '0;
         bus.result_valid <= 1'b0;
         wait_cnt         <= '0;
      end else begin
         case (state)
            LOAD_A: begin
               if (press[0]) begin
                  bus.A <= bus.sw[WIDTH-1:0];
                  state <= LOAD_B;
               end
            end
            LOAD_B: begin
               if (press[0]) begin
                  bus.B <= bus.sw[WIDTH-1:0];
                  state <= LOAD_OP;
               end
            end
            LOAD_OP: begin
               if (press[0]) begin
                  bus.op   <= bus.sw[OPW-1:0];
                  wait_cnt <= WAIT_INIT;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               // enter presses arriving here are dropped, not remembered
               if (wait_cnt == '0) begin
                  bus.result       <= bus.alu_y;
                  bus.result_valid <= 1'b1;
                  state            <= SHOW;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            SHOW: begin
               if (press[0]) begin
                  bus.result_valid <= 1'b0;
                  state            <= LOAD_A;
               end
            end
            default: state <= LOAD_A;
         endcase
      end
   end

   assign bus.busy  = (state == WAIT);
   assign bus.phase = state;
endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
Front-end stage that feeds the registered ALU (4-bit operands, 4-bit op, 2-cycle latency) from a shared switch bank and two push-buttons. It synchronizes and debounces the buttons, then walks the user through A -> B -> op entry, holding each value stable on its output. After op entry it waits out the ALU pipeline latency, then captures the ALU result into a display register with a valid flag.

Parameters:
WIDTH, 4, operand/result width; must match the ALU width
OPW, 4, operation code width
SW_W, 4, switch bank width; must be >= WIDTH and >= OPW
DB_CYCLES, 4, consecutive stable cycles required to accept a debounced button level change; must be >= 1
ALU_LAT, 2, downstream ALU latency in clock edges from operand change to Y valid; must be >= 1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
sw  in  SW_W  raw switch bank, treated as static data and not synchronized
btn_enter  in  1  raw asynchronous button: capture/advance
btn_clear  in  1  raw asynchronous button: abort to LOAD_A
alu_y  in  WIDTH  ALU result input
A  out  WIDTH  operand A to ALU, registered
B  out  WIDTH  operand B to ALU, registered
op  out  OPW  operation to ALU, registered
result  out  WIDTH  captured ALU result
result_valid  out  1  result holds a completed operation
busy  out  1  high only in WAIT
phase  out  3  state code: 0 LOAD_A, 1 LOAD_B, 2 LOAD_OP, 3 WAIT, 4 SHOW

Behaviour:
- Reset, asynchronous and immediate with no clock required: A=B=op=result=0, result_valid=0, busy=0, phase=0 (LOAD_A), sync flops=0, debounced levels=0, debounce counters=0, wait counter=0. This also applies to reset asserted mid-operation.
- Button path, per button:
  - Two-flop synchronizer.
  - Debouncer: if the synced level differs from the debounced level for DB_CYCLES consecutive cycles, the debounced level flips. Any agreeing cycle zeroes the counter.
  - Press pulse: 1-cycle pulse on the rising edge of the debounced level.
  - A held button produces exactly one press. A pulse shorter than DB_CYCLES produces none.
  - Latency from raw rise to press pulse: 2 + DB_CYCLES cycles.
- FSM, where a press means the registered press pulse:
  - LOAD_A: enter -> A <= sw[WIDTH-1:0]; go to LOAD_B.
  - LOAD_B: enter -> B <= sw[WIDTH-1:0]; go to LOAD_OP.
  - LOAD_OP: enter -> op <= sw[OPW-1:0]; wait counter <= ALU_LAT; go to WAIT.
  - WAIT: if counter == 0, then result <= alu_y, result_valid <= 1, go to SHOW. Otherwise decrement the counter.
  - WAIT timing: occupies exactly ALU_LAT+1 cycles. Result is captured on the (ALU_LAT+1)-th edge after the op-capture edge, one edge after ALU Y settles. Enter presses in WAIT are ignored and discarded, not queued.
  - SHOW: enter -> result_valid <= 0; go to LOAD_A. A, B, op and result are held.
- A, B and op change only on their own capture edge. They hold their values in all other states, including SHOW and the next LOAD_A, until overwritten.
- Clear press in any state: A=B=op=0, result=0, result_valid=0, counter=0, go to LOAD_A.
- Simultaneous clear and enter presses: clear wins; enter is discarded.
- Output timing: busy and phase are decoded from the state register and change on the transition edge. result_valid is registered.
- Wait counter width: $clog2(ALU_LAT+1) bits. No wrap is possible.

Test Plan:
- Setup for all scenarios: DB_CYCLES=4, ALU_LAT=2; bench ALU model returns A+B with 2-edge latency.
- Basic flow: reset; enter with sw=3, sw=5, sw=0, holding each press 8 cycles -> A=3, B=5, op=0; busy high for exactly 3 cycles; result=8 and result_valid=1 on the 3rd edge after WAIT entry; phase=4.
- Glitch rejection: btn_enter high 3 cycles then low, in LOAD_A -> no press; phase stays 0; A unchanged.
- Held button: btn_enter held 50 cycles in LOAD_A with sw=9 -> A=9; phase advances 0->1 only once; press pulse exactly 6 cycles after raw rise.
- Busy lockout: full press during WAIT -> ignored; SHOW reached on schedule; result unchanged by that press; no extra advance afterwards.
- Clear priority: in LOAD_OP with A=7, B=2, raw clear and enter rise in the same cycle -> phase=0; A=B=op=0; result_valid=0.
- Async reset: assert reset between clock edges during WAIT -> all outputs 0 and phase=0 before the next edge; after release, the normal flow gives correct results.
